// File: rtl/i2c_target.sv
// ---------------------------------------------------------------------------
// i2c_target -- I2C target (slave) with an 8-bit register-pointer interface.
//
// The host addresses the target, writes a register pointer, then either
// writes data bytes (one reg_we strobe per byte, pointer auto-increments) or
// issues a repeated START with R/W=1 and reads bytes (one reg_re strobe per
// byte, pointer auto-increments). SCL is never driven (no clock stretching).
//
// Ports
//   clk             in   system clock, all logic on rising edge
//   reset           in   synchronous, active-high
//   i2c_scl_in      in   raw SCL pad level (asynchronous)
//   i2c_sda_in      in   raw SDA pad level (asynchronous)
//   i2c_sda_drive_n out  0 pulls SDA low, 1 releases it (open-drain)
//   reg_addr        out  register pointer
//   reg_wdata       out  write data, qualified by reg_we
//   reg_we          out  one-cycle write strobe
//   reg_re          out  one-cycle read strobe; reg_rdata sampled that cycle
//   reg_rdata       in   read data, combinational from reg_addr
//   busy            out  high from address-match ACK until next START/STOP
// ---------------------------------------------------------------------------
module i2c_target #(
  parameter logic [6:0] ADDRESS = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl_in,
  input  logic       i2c_sda_in,
  output logic       i2c_sda_drive_n,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_BYTE  = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD_BYTE  = 3'd5,
    ST_RD_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } state_e;

  // Input conditioning: 2-flop synchroniser, then two history samples.
  logic       scl_meta_q, scl_sync_q, scl_filt_q, scl_prev_q, scl_filt_d;
  logic       sda_meta_q, sda_sync_q, sda_filt_q, sda_prev_q, sda_filt_d;
  logic [1:0] scl_hist_q, sda_hist_q;

  // Bus events derived from the filtered levels.
  logic scl_rise_s, scl_fall_s, start_s, stop_s;

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;        // lower 7 bits of incoming byte
  logic [6:0] rd_shift_q, rd_shift_d;  // remaining read bits, MSB in [6]
  logic       rw_q, rw_d;
  logic       phase_q, phase_d;        // second half of an ACK slot
  logic       first_q, first_d;        // next write byte is the pointer
  logic       drive_n_q, drive_n_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic       busy_q, busy_d;
  logic [7:0] byte_s;

  // Synchroniser, history and filtered-level registers for SCL and SDA.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_hist_q <= 2'b11;
      sda_filt_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= i2c_scl_in;
      scl_sync_q <= scl_meta_q;
      scl_hist_q <= {scl_hist_q[0], scl_sync_q};
      scl_filt_q <= scl_filt_d;
      scl_prev_q <= scl_filt_q;
      sda_meta_q <= i2c_sda_in;
      sda_sync_q <= sda_meta_q;
      sda_hist_q <= {sda_hist_q[0], sda_sync_q};
      sda_filt_q <= sda_filt_d;
      sda_prev_q <= sda_filt_q;
    end
  end

  // Agreement filter: the filtered level follows only three equal samples.
  always_comb begin
    scl_filt_d = scl_filt_q;
    sda_filt_d = sda_filt_q;
    if ((scl_sync_q == scl_hist_q[0]) && (scl_hist_q[0] == scl_hist_q[1])) begin
      scl_filt_d = scl_sync_q;
    end else begin
      scl_filt_d = scl_filt_q;
    end
    if ((sda_sync_q == sda_hist_q[0]) && (sda_hist_q[0] == sda_hist_q[1])) begin
      sda_filt_d = sda_sync_q;
    end else begin
      sda_filt_d = sda_filt_q;
    end
  end

  // SDA edges only count as START/STOP when SCL was high on both samples.
  assign scl_rise_s = scl_filt_q & ~scl_prev_q;
  assign scl_fall_s = ~scl_filt_q & scl_prev_q;
  assign start_s    = scl_filt_q & scl_prev_q & ~sda_filt_q & sda_prev_q;
  assign stop_s     = scl_filt_q & scl_prev_q & sda_filt_q & ~sda_prev_q;
  assign byte_s     = {shift_q, sda_filt_q};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; STOP and START override every state.
  always_comb begin
    state_d = state_q;
    if (stop_s) begin
      state_d = ST_IDLE;
    end else if (start_s) begin
      state_d = ST_ADDR;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ADDR: begin
          if (scl_rise_s && (bit_cnt_q == 4'd7)) begin
            state_d = (byte_s[7:1] == ADDRESS) ? ST_ADDR_ACK : ST_IGNORE;
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall_s && phase_q) begin
            state_d = rw_q ? ST_RD_BYTE : ST_WR_BYTE;
          end else begin
            state_d = ST_ADDR_ACK;
          end
        end
        ST_WR_BYTE: begin
          if (scl_rise_s && (bit_cnt_q == 4'd7)) begin
            state_d = ST_WR_ACK;
          end else begin
            state_d = ST_WR_BYTE;
          end
        end
        ST_WR_ACK: begin
          if (scl_fall_s && phase_q) begin
            state_d = ST_WR_BYTE;
          end else begin
            state_d = ST_WR_ACK;
          end
        end
        ST_RD_BYTE: begin
          if (scl_rise_s && (bit_cnt_q == 4'd7)) begin
            state_d = ST_RD_ACK;
          end else begin
            state_d = ST_RD_BYTE;
          end
        end
        ST_RD_ACK: begin
          // Host NACK (SDA high on the 9th rising edge) ends the read.
          if (scl_rise_s && sda_filt_q) begin
            state_d = ST_IGNORE;
          end else if (scl_fall_s && phase_q) begin
            state_d = ST_RD_BYTE;
          end else begin
            state_d = ST_RD_ACK;
          end
        end
        ST_IGNORE: begin
          state_d = ST_IGNORE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM output / datapath next-state logic.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rd_shift_d = rd_shift_q;
    rw_d       = rw_q;
    phase_d    = phase_q;
    first_d    = first_q;
    drive_n_d  = drive_n_q;
    ptr_d      = ptr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    busy_d     = busy_q;

    // The pointer advances the cycle after each strobe.
    if (we_q || re_q) begin
      ptr_d = ptr_q + 8'd1;
    end else begin
      ptr_d = ptr_q;
    end

    // reg_rdata is valid while reg_re is high: load it and drive the MSB.
    if (re_q) begin
      rd_shift_d = reg_rdata[6:0];
      drive_n_d  = reg_rdata[7];
    end else begin
      rd_shift_d = rd_shift_q;
    end

    case (state_q)
      ST_ADDR: begin
        if (scl_rise_s) begin
          shift_d   = byte_s[6:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            rw_d      = sda_filt_q;
            phase_d   = 1'b0;
            bit_cnt_d = 4'd0;
          end else begin
            rw_d = rw_q;
          end
        end else begin
          shift_d = shift_q;
        end
      end
      ST_ADDR_ACK: begin
        if (scl_fall_s) begin
          if (!phase_q) begin
            drive_n_d = 1'b0;
            busy_d    = 1'b1;
            phase_d   = 1'b1;
          end else begin
            drive_n_d = 1'b1;
            phase_d   = 1'b0;
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              re_d = 1'b1;
            end else begin
              first_d = 1'b1;
            end
          end
        end else begin
          phase_d = phase_q;
        end
      end
      ST_WR_BYTE: begin
        if (scl_rise_s) begin
          shift_d   = byte_s[6:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            phase_d   = 1'b0;
            if (first_q) begin
              ptr_d   = byte_s;
              first_d = 1'b0;
            end else begin
              we_d    = 1'b1;
              wdata_d = byte_s;
            end
          end else begin
            phase_d = phase_q;
          end
        end else begin
          shift_d = shift_q;
        end
      end
      ST_WR_ACK: begin
        if (scl_fall_s) begin
          drive_n_d = phase_q;
          phase_d   = ~phase_q;
        end else begin
          phase_d = phase_q;
        end
      end
      ST_RD_BYTE: begin
        if (scl_rise_s) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            phase_d   = 1'b0;
          end else begin
            phase_d = phase_q;
          end
        end else if (scl_fall_s && (bit_cnt_q != 4'd0)) begin
          drive_n_d  = rd_shift_q[6];
          rd_shift_d = {rd_shift_q[5:0], 1'b0};
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      ST_RD_ACK: begin
        if (scl_fall_s && !phase_q) begin
          drive_n_d = 1'b1;
        end else if (scl_rise_s && !sda_filt_q) begin
          phase_d = 1'b1;
        end else if (scl_fall_s && phase_q) begin
          phase_d   = 1'b0;
          bit_cnt_d = 4'd0;
          re_d      = 1'b1;
        end else begin
          phase_d = phase_q;
        end
      end
      default: begin
        bit_cnt_d = bit_cnt_q;
      end
    endcase

    // Bus conditions abort the byte in flight; strobes already earned stand.
    if (stop_s || start_s) begin
      drive_n_d = 1'b1;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
      phase_d   = 1'b0;
      first_d   = 1'b0;
    end else begin
      busy_d = busy_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q  <= 4'd0;
      shift_q    <= 7'd0;
      rd_shift_q <= 7'd0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      first_q    <= 1'b0;
      drive_n_q  <= 1'b1;
      ptr_q      <= 8'd0;
      wdata_q    <= 8'd0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rd_shift_q <= rd_shift_d;
      rw_q       <= rw_d;
      phase_q    <= phase_d;
      first_q    <= first_d;
      drive_n_q  <= drive_n_d;
      ptr_q      <= ptr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      busy_q     <= busy_d;
    end
  end

  assign i2c_sda_drive_n = drive_n_q;
  assign reg_addr        = ptr_q;
  assign reg_wdata       = wdata_q;
  assign reg_we          = we_q;
  assign reg_re          = re_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
module tb_i2c_target;
  localparam int Q = 8;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_h;
  logic       sda_h;
  logic       sda_bus;
  logic       i2c_sda_drive_n;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy;

  int checks = 0;
  int errors = 0;
  int low_total = 0;
  logic [15:0] we_q[$];
  logic [7:0]  re_q[$];

  function automatic logic [7:0] rd_model(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'hC3;
  endfunction

  assign sda_bus   = sda_h & i2c_sda_drive_n;
  assign reg_rdata = rd_model(reg_addr);

  i2c_target #(.ADDRESS(7'h50)) dut (
    .clk(clk),
    .reset(reset),
    .i2c_scl_in(scl_h),
    .i2c_sda_in(sda_bus),
    .i2c_sda_drive_n(i2c_sda_drive_n),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we(reg_we),
    .reg_re(reg_re),
    .reg_rdata(reg_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Strobe scoreboard and SDA-low activity counter, sampled on the falling clk edge.
  always @(negedge clk) begin
    if (!reset && reg_we) begin
      check("we_expected", 16'(we_q.size() != 0), 16'd1);
      if (we_q.size() != 0) check("we_addr_data", {reg_addr, reg_wdata}, we_q.pop_front());
    end
    if (!reset && reg_re) begin
      check("re_expected", 16'(re_q.size() != 0), 16'd1);
      if (re_q.size() != 0) check("re_addr", 16'(reg_addr), 16'(re_q.pop_front()));
    end
    if (!i2c_sda_drive_n) low_total++;
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_c;
    wclk(Q); sda_h = 1'b1; wclk(Q); scl_h = 1'b1; wclk(2*Q);
    sda_h = 1'b0; wclk(2*Q); scl_h = 1'b0;
  endtask

  task automatic stop_c;
    wclk(Q); sda_h = 1'b0; wclk(Q); scl_h = 1'b1; wclk(2*Q);
    sda_h = 1'b1; wclk(2*Q);
  endtask

  task automatic bit_c(input logic b, output logic r);
    wclk(Q); sda_h = b; wclk(Q); scl_h = 1'b1; wclk(2*Q);
    r = sda_bus; scl_h = 1'b0;
  endtask

  // Bit with a 2-clk SCL low glitch and a 2-clk SDA glitch while SCL is high.
  task automatic bit_g(input logic b, output logic r);
    wclk(Q); sda_h = b; wclk(Q); scl_h = 1'b1; wclk(Q);
    scl_h = 1'b0; wclk(2); scl_h = 1'b1; wclk(3);
    sda_h = ~b; wclk(2); sda_h = b; wclk(Q);
    r = sda_bus; scl_h = 1'b0;
  endtask

  task automatic write_byte(input string tag, input logic [7:0] b, input logic glitch, output logic ack);
    logic r;
    logic [7:0] echo;
    echo = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      if (glitch) bit_g(b[i], r);
      else bit_c(b[i], r);
      echo = {echo[6:0], r};
    end
    check({tag, "_echo"}, 16'(echo), 16'(b));
    bit_c(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    logic r;
    b = 8'd0;
    for (int i = 0; i < 8; i++) begin
      bit_c(1'b1, r);
      b = {b[6:0], r};
    end
    bit_c(ack ? 1'b0 : 1'b1, r);
  endtask

  initial begin
    logic ack;
    logic r;
    logic [7:0] d;
    int snap;

    reset = 1'b1; scl_h = 1'b1; sda_h = 1'b1;
    wclk(4);
    check("rst_drive_n", 16'(i2c_sda_drive_n), 16'd1);
    check("rst_addr", 16'(reg_addr), 16'd0);
    check("rst_wdata", 16'(reg_wdata), 16'd0);
    check("rst_strobes", 16'({reg_we, reg_re}), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    reset = 1'b0;
    wclk(10);

    // Write pointer 0x10 then two data bytes.
    start_c;
    write_byte("t1_a", 8'hA0, 1'b0, ack); check("t1_addr_ack", 16'(ack), 16'd1);
    check("t1_busy", 16'(busy), 16'd1);
    write_byte("t1_p", 8'h10, 1'b0, ack); check("t1_ptr_ack", 16'(ack), 16'd1);
    we_q.push_back({8'h10, 8'h55});
    write_byte("t1_d0", 8'h55, 1'b0, ack); check("t1_d0_ack", 16'(ack), 16'd1);
    we_q.push_back({8'h11, 8'hAA});
    write_byte("t1_d1", 8'hAA, 1'b0, ack); check("t1_d1_ack", 16'(ack), 16'd1);
    stop_c; wclk(4);
    check("t1_final_addr", 16'(reg_addr), 16'h0012);
    check("t1_busy_end", 16'(busy), 16'd0);
    check("t1_we_drained", 16'(we_q.size()), 16'd0);

    // Pointer 0x20, repeated START, read two bytes (ACK then NACK).
    start_c;
    write_byte("t2_a", 8'hA0, 1'b0, ack); check("t2_addr_ack", 16'(ack), 16'd1);
    write_byte("t2_p", 8'h20, 1'b0, ack); check("t2_ptr_ack", 16'(ack), 16'd1);
    start_c;
    re_q.push_back(8'h20); re_q.push_back(8'h21);
    write_byte("t2_ar", 8'hA1, 1'b0, ack); check("t2_raddr_ack", 16'(ack), 16'd1);
    read_byte(1'b1, d); check("t2_rd0", 16'(d), 16'(rd_model(8'h20)));
    read_byte(1'b0, d); check("t2_rd1", 16'(d), 16'(rd_model(8'h21)));
    check("t2_busy_before_stop", 16'(busy), 16'd1);
    stop_c; wclk(4);
    check("t2_busy_after_stop", 16'(busy), 16'd0);
    check("t2_final_addr", 16'(reg_addr), 16'h0022);
    check("t2_re_drained", 16'(re_q.size()), 16'd0);

    // Foreign address: never drive SDA, no strobes, not busy.
    snap = low_total;
    start_c;
    write_byte("t3_a", 8'hB0, 1'b0, ack); check("t3_addr_nack", 16'(ack), 16'd0);
    write_byte("t3_d", 8'h12, 1'b0, ack); check("t3_data_nack", 16'(ack), 16'd0);
    check("t3_busy", 16'(busy), 16'd0);
    stop_c; wclk(4);
    check("t3_sda_low_cycles", 16'(low_total - snap), 16'd0);
    check("t3_addr_kept", 16'(reg_addr), 16'h0022);

    // Pointer wrap 0xFF -> 0x00.
    start_c;
    write_byte("t4_a", 8'hA0, 1'b0, ack); check("t4_addr_ack", 16'(ack), 16'd1);
    write_byte("t4_p", 8'hFF, 1'b0, ack);
    we_q.push_back({8'hFF, 8'h33});
    write_byte("t4_d0", 8'h33, 1'b0, ack); check("t4_d0_ack", 16'(ack), 16'd1);
    we_q.push_back({8'h00, 8'h44});
    write_byte("t4_d1", 8'h44, 1'b0, ack); check("t4_d1_ack", 16'(ack), 16'd1);
    stop_c; wclk(4);
    check("t4_final_addr", 16'(reg_addr), 16'h0001);

    // STOP after 4 bits of a data byte.
    start_c;
    write_byte("t5_a", 8'hA0, 1'b0, ack);
    write_byte("t5_p", 8'h40, 1'b0, ack);
    bit_c(1'b1, r); bit_c(1'b0, r); bit_c(1'b1, r); bit_c(1'b1, r);
    stop_c; wclk(4);
    check("t5_drive_n", 16'(i2c_sda_drive_n), 16'd1);
    check("t5_busy", 16'(busy), 16'd0);
    check("t5_state_idle", 16'(dut.state_q), 16'd0);
    check("t5_addr", 16'(reg_addr), 16'h0040);

    // Glitched pointer byte must still load exactly 0x60.
    start_c;
    write_byte("t6_a", 8'hA0, 1'b0, ack);
    write_byte("t6_p", 8'h60, 1'b1, ack); check("t6_ptr_ack", 16'(ack), 16'd1);
    check("t6_busy", 16'(busy), 16'd1);
    we_q.push_back({8'h60, 8'h77});
    write_byte("t6_d", 8'h77, 1'b0, ack); check("t6_d_ack", 16'(ack), 16'd1);
    stop_c; wclk(4);
    check("t6_final_addr", 16'(reg_addr), 16'h0061);

    // Reset while the address ACK is being driven.
    start_c;
    for (int i = 7; i >= 0; i--) bit_c(1'b0 ^ (8'hA0 >> i) & 8'h01 ? 1'b1 : 1'b0, r);
    sda_h = 1'b1;
    wclk(Q);
    check("t7_ack_driven", 16'(i2c_sda_drive_n), 16'd0);
    reset = 1'b1; wclk(1);
    check("t7_reset_release", 16'(i2c_sda_drive_n), 16'd1);
    check("t7_reset_busy", 16'(busy), 16'd0);
    reset = 1'b0;
    wclk(Q); scl_h = 1'b1; wclk(2*Q); scl_h = 1'b0;
    write_byte("t7_d", 8'h55, 1'b0, ack); check("t7_ignored_nack", 16'(ack), 16'd0);
    check("t7_busy", 16'(busy), 16'd0);
    stop_c; wclk(4);

    // Normal operation resumes after a fresh START.
    start_c;
    write_byte("t8_a", 8'hA0, 1'b0, ack); check("t8_addr_ack", 16'(ack), 16'd1);
    write_byte("t8_p", 8'h05, 1'b0, ack);
    we_q.push_back({8'h05, 8'h99});
    write_byte("t8_d", 8'h99, 1'b0, ack); check("t8_d_ack", 16'(ack), 16'd1);
    stop_c; wclk(4);
    check("t8_final_addr", 16'(reg_addr), 16'h0006);
    check("end_we_drained", 16'(we_q.size()), 16'd0);
    check("end_re_drained", 16'(re_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
